vedic_div_8_by_4: RTL and testbench

- Sequential 8-bit by 4-bit unsigned divider. It is the inverse companion to the 4x4 Vedic multiplier in the same arithmetic library.
- Produces an 8-bit quotient and a 4-bit remainder using restoring division, one quotient bit per clock.
- Start/busy/done handshake, for use by datapath controllers that must undo or check a prior multiply.

---
 rtl/vedic_div_8_by_4.sv | 83 ++++++++
 tb/tb_vedic_div_8_by_4.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vedic_div_8_by_4.sv
// vedic_div_8_by_4: sequential restoring divider, one quotient bit per clock
module vedic_div_8_by_4 #(
  parameter int DW = 8,
  parameter int VW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dvd, quo;
  logic [VW-1:0] dvs, rem, rem_n;
  logic [VW:0] trial;
  logic [CW-1:0] count;
  logic qbit;
  assign ready = state == IDLE;
  assign busy = state == CALC;
  assign done = state == DONE;
  // trial subtract and next state
  always_comb begin
    trial = {rem, dvd[DW-1]};
    qbit = trial >= {1'b0, dvs};
    rem_n = qbit ? VW'(trial - {1'b0, dvs}) : trial[VW-1:0];
    state_n = state == IDLE ? (start ? (b == '0 ? DONE : CALC) : IDLE) :
              state == CALC ? (count == '0 ? DONE : CALC) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // datapath: operand latch, shift/subtract step, result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      count <= '0;
      q <= '0;
      r <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            if (b != '0) begin
              dvd <= a;
              dvs <= b;
              rem <= '0;
              quo <= '0;
              count <= CW'(DW - 1);
            end else begin
              q <= '1;
              r <= '0;
              div_by_zero <= 1'b1;
            end
          end
        CALC: begin
          rem <= rem_n;
          quo <= {quo[DW-2:0], qbit};
          dvd <= dvd << 1;
          count <= count - CW'(1);
          if (count == '0) begin
            q <= {quo[DW-2:0], qbit};
            r <= rem_n;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_div_8_by_4.sv
// tb_vedic_div_8_by_4: scoreboard bench with arithmetic reference model
module tb_vedic_div_8_by_4;
  logic clk = 0, rst = 0, start = 0;
  logic [7:0] a = 0;
  logic [3:0] b = 0;
  logic ready, busy, done, div_by_zero;
  logic [7:0] q;
  logic [3:0] r;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0, failures = 0, issued = 0, done_count = 0;
  logic [7:0] hq = 0;
  logic [3:0] hr = 0;
  logic hz = 0;

  vedic_div_8_by_4 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ia, input logic [3:0] ib);
    exp_t x;
    x.a = ia;
    x.b = ib;
    x.dz = (ib == 0);
    x.q = x.dz ? 8'hFF : 8'(int'(ia) / int'(ib));
    x.r = x.dz ? 4'd0 : 4'(int'(ia) % int'(ib));
    return x;
  endfunction

  // monitor: score every done, require outputs stable otherwise
  always @(negedge clk) begin
    if (rst) begin
      hq = 0; hr = 0; hz = 0;
    end else if (done) begin
      done_count++;
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        if (!e.dz) begin
          chk("q_times_b_plus_r", 32'(q) * 32'(e.b) + 32'(r), 32'(e.a));
          chk("r_below_b", 32'(r < e.b), 1);
        end
      end
      hq = q; hr = r; hz = div_by_zero;
    end else begin
      chk("hold_q", q, hq);
      chk("hold_r", r, hr);
      chk("hold_dz", div_by_zero, hz);
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [3:0] ib, input bit push, input bit hold);
    int t = 0;
    while (!ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("ready_timeout", 0, 1);
    a = ia; b = ib; start = 1;
    if (push) begin exp_q.push_back(model(ia, ib)); issued++; end
    @(negedge clk);
    if (!hold) start = 0;
  endtask

  task automatic run_timed(input logic [7:0] ia, input logic [3:0] ib);
    int n = 0, t = 0;
    issue(ia, ib, 1, 0);
    while (!done && t < 40) begin if (busy) n++; @(negedge clk); t++; end
    chk("latency", t, ib == 0 ? 0 : 8);
    chk("busy_cycles", n, ib == 0 ? 0 : 8);
    chk("ready_low_in_done", ready, 0);
    @(negedge clk);
    chk("ready_after_done", ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, dc;
    #3 rst = 1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk); @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    run_timed(200, 7);
    run_timed(255, 15);
    run_timed(5, 9);
    run_timed(255, 1);
    run_timed(77, 0);
    run_timed(77, 3);
    // start/operand changes during CALC and DONE must be ignored
    dc = done_count;
    issue(100, 10, 1, 0);
    @(negedge clk);
    a = 9; b = 3; start = 1;
    @(negedge clk); @(negedge clk);
    start = 0; a = 8'($urandom); b = 4'($urandom);
    t = 0;
    while (!done && t < 40) begin @(negedge clk); t++; end
    chk("ignore_done_seen", 32'(done), 1);
    start = 1; a = 9; b = 3;
    @(negedge clk);
    start = 0;
    repeat (15) @(negedge clk);
    chk("single_done", done_count, dc + 1);
    // asynchronous reset in the 4th CALC cycle
    dc = done_count;
    issue(200, 3, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_dz", div_by_zero, 0);
    @(negedge clk);
    #2 rst = 0;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", done_count, dc);
    run_timed(64, 8);
    // randomized operations with random idle gaps
    repeat (150) begin
      issue(8'($urandom), 4'($urandom_range(0, 15)), 1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // exhaustive sweep, start held high
    for (int i = 0; i < 4096; i++) issue(8'(i >> 4), 4'(i), 1, 1);
    start = 0;
    repeat (20) @(negedge clk);
    chk("done_count", done_count, issued);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
